uart_tx_ctrl: RTL and testbench

UART transmit sequencer that owns and drives one `tim` baud timer instance. It accepts a byte over a valid/ready handshake and restarts the timer at frame start. It then shifts out start, data (LSB first), optional parity and stop bits on `txd`, advancing one bit per timer alarm. It sits between the host-side byte interface and the serial pin, and is the only agent allowed to enable or reset its timer.

---
 rtl/uart_tx_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer driving one external baud timer.
// Accepts a data word over valid/ready, restarts the timer at frame start, then
// shifts out start, data (LSB first), optional parity and stop bits, one bit per alarm.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   tx_data    word to send            tx_valid  host offers tx_data
//   tx_ready   high only when idle     cfg_div   divisor N, bit period N+1 clocks
//   tim_cnt    timer compare value     tim_en    timer enable
//   tim_rst    timer synchronous clear tim_alarm timer alarm, one pulse per bit period
//   txd        serial line, idles high tx_done   one-cycle pulse at frame end
module uart_tx_ctrl #(
  parameter int unsigned DBITS  = 8,
  parameter int unsigned bbits  = 16,
  parameter int unsigned PARITY = 0,
  parameter int unsigned STOP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DBITS-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [bbits-1:0] cfg_div,
  output logic [bbits-1:0] tim_cnt,
  output logic             tim_en,
  output logic             tim_rst,
  input  logic             tim_alarm,
  output logic             txd,
  output logic             tx_done
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  localparam logic [3:0] LastIdx  = 4'(DBITS - 1);
  localparam logic [1:0] LastStop = 2'(STOP - 1);

  state_e           state_q, state_d;
  logic [DBITS-1:0] shift_q, shift_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       stop_q, stop_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic [bbits-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    txd_d   = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          shift_d = tx_data;
          cnt_d   = cfg_div;
          par_d   = (PARITY == 2) ? ~(^tx_data) : ^tx_data;
          idx_d   = '0;
          stop_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tim_alarm) state_d = StData;
      end
      StData: begin
        if (tim_alarm) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 4'd1;
          if (idx_q == LastIdx) state_d = (PARITY != 0) ? StPar : StStop;
        end
      end
      StPar: begin
        if (tim_alarm) state_d = StStop;
      end
      StStop: begin
        if (tim_alarm) begin
          if (stop_q == LastStop) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is registered from the next state so each bit appears one clock after its edge.
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      StPar:   txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  assign tx_ready = (state_q == StIdle);
  assign tim_en   = (state_q != StIdle);
  // Clearing on every idle valid guarantees the timer starts from zero on the accept edge.
  assign tim_rst  = rst | ((state_q == StIdle) & tx_valid);
  assign tim_cnt  = cnt_q;
  assign txd      = txd_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;
  localparam int DBITS  = 8;
  localparam int BBITS  = 16;
  localparam int PARITY = 2;
  localparam int STOP   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [DBITS-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [BBITS-1:0] cfg_div;
  logic [BBITS-1:0] tim_cnt;
  logic             tim_en;
  logic             tim_rst;
  logic             tim_alarm;
  logic             txd;
  logic             tx_done;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .DBITS (DBITS),
    .bbits (BBITS),
    .PARITY(PARITY),
    .STOP  (STOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .cfg_div  (cfg_div),
    .tim_cnt  (tim_cnt),
    .tim_en   (tim_en),
    .tim_rst  (tim_rst),
    .tim_alarm(tim_alarm),
    .txd      (txd),
    .tx_done  (tx_done)
  );

  // Baud timer environment: count up to tim_cnt, alarm while at it, wrap.
  logic [BBITS-1:0] tcnt;
  logic             force_alarm = 1'b0;
  always @(posedge clk) begin
    if (tim_rst) tcnt <= '0;
    else if (tim_en) tcnt <= (tcnt == tim_cnt) ? '0 : tcnt + 1'b1;
  end
  assign tim_alarm = (tim_en && (tcnt == tim_cnt)) || force_alarm;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Scoreboard entries: {divisor, data}
  logic [23:0] exp_q[$];

  // Monitor: capture each frame on txd, compare with the reference waveform at tx_done.
  bit          in_frame = 0;
  bit          ctrl_bad;
  logic        samples[$];
  logic        ref_bits[$];
  logic [23:0] m_e;
  int          m_div;
  int          mism;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
    end else if (!in_frame) begin
      if (tx_done) check("stray_done", 1, 0);
      if (txd === 1'b0) begin
        in_frame = 1;
        samples.delete();
        samples.push_back(txd);
        ctrl_bad = (tx_ready !== 1'b0) || (tim_en !== 1'b1);
      end
    end else if (tx_done) begin
      in_frame = 0;
      if (exp_q.size() == 0) begin
        check("frame_unexpected", 1, 0);
      end else begin
        m_e   = exp_q.pop_front();
        m_div = int'(m_e[23:8]);
        ref_bits.delete();
        // Frame: start 0, data LSB first, odd parity, STOP stop bits; each bit N+1 clocks.
        for (int b = 0; b < 1 + DBITS + 1 + STOP; b++) begin
          logic bitv;
          if (b == 0) bitv = 1'b0;
          else if (b <= DBITS) bitv = m_e[b-1];
          else if (b == DBITS + 1) bitv = ($countones(m_e[7:0]) % 2 == 0);
          else bitv = 1'b1;
          for (int k = 0; k <= m_div; k++) ref_bits.push_back(bitv);
        end
        check("frame_len", samples.size(), ref_bits.size());
        mism = -1;
        for (int i = 0; i < samples.size() && i < ref_bits.size(); i++)
          if (mism < 0 && samples[i] !== ref_bits[i]) mism = i;
        check("frame_bits_first_bad_idx", mism, -1);
        check("ctrl_during_frame", ctrl_bad, 0);
        check("ready_with_done", tx_ready, 1);
        check("txd_high_at_done", txd, 1);
      end
    end else begin
      samples.push_back(txd);
      if (tx_ready !== 1'b0 || tim_en !== 1'b1) ctrl_bad = 1;
      if (samples.size() > 3000) begin
        check("frame_timeout", 1, 0);
        in_frame = 0;
      end
    end
  end

  // Wait for readiness at negedges, optionally scrambling ignored inputs meanwhile.
  task automatic wait_ready(input bit noisy, output bit waited);
    int guard = 0;
    waited = 0;
    while (!tx_ready) begin
      waited = 1;
      if (noisy) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
        cfg_div  = 16'($urandom_range(0, 7));
      end
      @(negedge clk);
      if (++guard > 3000) begin
        $display("FAIL ready_timeout: tx_ready stuck low");
        $fatal(1);
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input int div, input bit noisy);
    bit waited;
    @(negedge clk);
    wait_ready(noisy, waited);
    if (waited) check("done_with_ready", tx_done, 1);
    tx_data  = d;
    cfg_div  = 16'(div);
    tx_valid = 1'b1;
    exp_q.push_back({div[15:0], d});
    @(posedge clk);
    #1 check("busy_after_accept", tx_ready, 0);
  endtask

  task automatic idle_gap(input int n);
    bit waited;
    @(negedge clk);
    wait_ready(1'b1, waited);
    tx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    bit waited;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    cfg_div  = '0;
    #1;
    check("rst_txd", txd, 1);
    check("rst_done", tx_done, 0);
    check("rst_tim_cnt", tim_cnt, 0);
    check("rst_tim_en", tim_en, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_tim_rst", tim_rst, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic frame and short-divisor frame
    send(8'hA5, 3, 1'b0);
    idle_gap(2);
    send(8'h03, 0, 1'b0);
    // Back-to-back with valid held high
    send(8'h55, 2, 1'b0);
    send(8'hAA, 1, 1'b0);
    // Divisor changes mid-frame must not matter
    send(8'h5A, 5, 1'b1);
    send(8'hC6, 1, 1'b1);
    idle_gap(1);

    // Alarm pulses in idle cause nothing
    force_alarm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_alarm_txd", txd, 1);
      check("idle_alarm_ready", tx_ready, 1);
      check("idle_alarm_en", tim_en, 0);
    end
    force_alarm = 1'b0;

    // Asynchronous reset during the start bit
    @(negedge clk);
    tx_data  = 8'h3C;
    cfg_div  = 16'd3;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check("start_bit_low", txd, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_txd", txd, 1);
    check("async_rst_en", tim_en, 0);
    check("async_rst_tim_rst", tim_rst, 1);
    check("async_rst_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(8'hC3, 3, 1'b0);

    // Randomized frames
    for (int n = 0; n < 25; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) idle_gap(gap);
      send(8'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    idle_gap(1);

    begin
      int guard = 0;
      while ((exp_q.size() != 0 || in_frame) && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
